// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory slave.
// Optional error response is enabled with APB_SLVERR_EN.
package apb_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    localparam int BYTE_W = 8;

    function automatic int lane_cnt(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that times the wait states of one transfer.
// Saturates at zero; zero drives pready in the access phase.
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB slave with integrated word memory and wait states.
// Define APB_SLVERR_EN for out-of-range error responses.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int WAIT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic [WAIT_W-1:0]     wait_cycles,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int LANES = lane_cnt(DATA_W);
    localparam int OFF   = off_bits(DATA_W);
    localparam int IDX_W = ADDR_W - OFF;
    localparam int AW    = $clog2(DEPTH);

    apb_state_e state, next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  strb;
    logic              zero;
    logic              setup;
    logic              commit;
    logic              err;
    logic              err_in;
    logic [IDX_W-1:0]  pidx;
    logic [DATA_W-1:0] rd_val;
    logic              unused;

    assign pidx  = paddr[ADDR_W-1:OFF];
    assign setup = (state == IDLE) && psel && !penable;

`ifdef APB_SLVERR_EN
    // Compare one bit wider so DEPTH == 2**IDX_W never truncates to 0.
    assign err_in = ({1'b0, pidx} >= (IDX_W+1)'(DEPTH));
    assign pslverr = pready && err;
`else
    assign err_in  = 1'b0;
    assign pslverr = 1'b0;
`endif

    assign rd_val = err_in ? '0 : mem[pidx[AW-1:0]];
    assign pready = (state == ACCESS) && zero;
    assign commit = pready && psel && penable && wr && !err;

    apb_wait_ctr #(
        .WAIT_W (WAIT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (setup),
        .load_val (wait_cycles),
        .dec      (state == ACCESS),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    next = IDLE;
                end else if (penable && zero) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            wr     <= 1'b0;
            wdata  <= '0;
            strb   <= '0;
            err    <= 1'b0;
            prdata <= '0;
        end else if (setup) begin
            idx   <= pidx;
            wr    <= pwrite;
            wdata <= pwdata;
            strb  <= pstrb;
            err   <= err_in;
            if (!pwrite) begin
                prdata <= rd_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (commit && strb[i]) begin
                mem[idx[AW-1:0]][i*BYTE_W +: BYTE_W] <=
                    wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Offset bits and, in the wrapping build, high index bits are unused.
    assign unused = ^{paddr, idx};

endmodule
